// File: rtl/mainfsm_ws_if.sv
// Control bundle between the multicycle controller FSM and the decode/datapath side.
// The master modport is the FSM; the slave modport is whoever supplies opcode fields and handshakes.
interface mainfsm_ws_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       FPUDone;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       MemReq;
    logic       FPUStart;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, Funct, MemReady, FPUDone,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
               Branch, ALUOp, MemReq, FPUStart, Fault, State
    );

    modport slave (
        output Op, Funct, MemReady, FPUDone,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
               Branch, ALUOp, MemReq, FPUStart, Fault, State
    );
endinterface

// File: rtl/mainfsm_ws.sv
// Multicycle ARM control FSM with variable-latency memory, FPU handshake and a sticky watchdog fault.
// Latency: Moore outputs registered alongside the state; NextPC/IRWrite follow MemReady in FETCH the same cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold on MemReady=0, FWAIT holds on FPUDone=0, each bounded by TIMEOUT.
module mainfsm_ws #(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          FPU_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mainfsm_ws_if.master  bus
);
    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam bit            WD_EN = (TIMEOUT != 0);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10,
        EXECUTEF = 4'd11,
        FWAIT    = 4'd12,
        FWB      = 4'd13
    } state_t;

    typedef struct packed {
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       memreq;
        logic       fpustart;
        logic       fault;
    } ctl_t;

    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.memreq = 1'b1; c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            MEMADR:   c.alusrcb = 2'b01;
            MEMRD:    begin c.adrsrc = 1'b1; c.memreq = 1'b1; end
            MEMWR:    begin c.adrsrc = 1'b1; c.memreq = 1'b1; c.memw = 1'b1; end
            MEMWB:    begin c.regw = 1'b1; c.resultsrc = 2'b01; end
            EXECUTER: c.aluop = 1'b1;
            EXECUTEI: begin c.aluop = 1'b1; c.alusrcb = 2'b01; end
            ALUWB:    c.regw = 1'b1;
            BRANCH:   begin c.branch = 1'b1; c.resultsrc = 2'b10; c.alusrcb = 2'b01; end
            EXECUTEF: c.fpustart = 1'b1;
            FWB:      begin c.regw = 1'b1; c.resultsrc = 2'b11; end
            FAULT:    c.fault = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    ctl_t          ctl;
    logic          expired;
    logic          unused_funct;

    assign expired      = WD_EN && (cnt == TMAX);
    assign unused_funct = ^bus.Funct[4:1];

    // A ready/done in the expiry cycle still takes the normal transition.
    always_comb begin
        nxt = state;
        case (state)
            FETCH:    if (bus.MemReady) nxt = DECODE;   else if (expired) nxt = FAULT;
            DECODE: begin
                case (bus.Op)
                    2'b00:   nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   nxt = MEMADR;
                    2'b10:   nxt = BRANCH;
                    default: nxt = FPU_EN ? EXECUTEF : FAULT;
                endcase
            end
            MEMADR:   nxt = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    if (bus.MemReady) nxt = MEMWB;   else if (expired) nxt = FAULT;
            MEMWR:    if (bus.MemReady) nxt = FETCH;   else if (expired) nxt = FAULT;
            FWAIT:    if (bus.FPUDone)  nxt = FWB;     else if (expired) nxt = FAULT;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            EXECUTEF: nxt = FWAIT;
            MEMWB:    nxt = FETCH;
            ALUWB:    nxt = FETCH;
            BRANCH:   nxt = FETCH;
            FWB:      nxt = FETCH;
            FAULT:    nxt = FAULT;
            default:  nxt = FAULT;
        endcase
    end

    // Only wait states and FAULT ever self-loop, so "state unchanged" means "still waiting".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cnt   <= '0;
            ctl   <= decode(FETCH);
        end else begin
            state <= nxt;
            ctl   <= decode(nxt);
            if (nxt != state)
                cnt <= '0;
            else if (cnt != TMAX)
                cnt <= cnt + CW'(1);
        end
    end

    // Strobes are gated by reset so they fall the instant reset asserts.
    assign bus.IRWrite   = (state == FETCH) && bus.MemReady && reset;
    assign bus.NextPC    = (state == FETCH) && bus.MemReady && reset;
    assign bus.AdrSrc    = ctl.adrsrc;
    assign bus.ALUSrcA   = ctl.alusrca;
    assign bus.ALUSrcB   = ctl.alusrcb;
    assign bus.ResultSrc = ctl.resultsrc;
    assign bus.RegW      = ctl.regw & reset;
    assign bus.MemW      = ctl.memw & reset;
    assign bus.Branch    = ctl.branch & reset;
    assign bus.ALUOp     = ctl.aluop;
    assign bus.MemReq    = ctl.memreq & reset;
    assign bus.FPUStart  = ctl.fpustart & reset;
    assign bus.Fault     = ctl.fault;
    assign bus.State     = state;
endmodule

// File: tb/tb_mainfsm_ws.sv
// Directed bench for mainfsm_ws: three instances (default, TIMEOUT=4, FPU_EN=0) checked cycle by cycle
// against a spec-derived output table through an expectation queue.
module tb_mainfsm_ws;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    localparam int UA = 0, UT = 1, UN = 2;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXER = 4'd6, S_EXEI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_FAULT = 4'd10, S_EXEF = 4'd11,
                           S_FWAIT = 4'd12, S_FWB = 4'd13;

    mainfsm_ws_if bus_a ();
    mainfsm_ws_if bus_t ();
    mainfsm_ws_if bus_n ();

    mainfsm_ws #(.TIMEOUT(16), .FPU_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));
    mainfsm_ws #(.TIMEOUT(4),  .FPU_EN(1'b1)) dut_t (.clk(clk), .reset(reset), .bus(bus_t.master));
    mainfsm_ws #(.TIMEOUT(16), .FPU_EN(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n.master));

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, MemReq, FPUStart, Fault, State}
    logic [19:0] va, vt, vn;
    assign va = {bus_a.IRWrite, bus_a.AdrSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ResultSrc, bus_a.NextPC,
                 bus_a.RegW, bus_a.MemW, bus_a.Branch, bus_a.ALUOp, bus_a.MemReq, bus_a.FPUStart,
                 bus_a.Fault, bus_a.State};
    assign vt = {bus_t.IRWrite, bus_t.AdrSrc, bus_t.ALUSrcA, bus_t.ALUSrcB, bus_t.ResultSrc, bus_t.NextPC,
                 bus_t.RegW, bus_t.MemW, bus_t.Branch, bus_t.ALUOp, bus_t.MemReq, bus_t.FPUStart,
                 bus_t.Fault, bus_t.State};
    assign vn = {bus_n.IRWrite, bus_n.AdrSrc, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ResultSrc, bus_n.NextPC,
                 bus_n.RegW, bus_n.MemW, bus_n.Branch, bus_n.ALUOp, bus_n.MemReq, bus_n.FPUStart,
                 bus_n.Fault, bus_n.State};

    typedef struct {
        string       tag;
        int          unit;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    // Output table written directly from the state/output description.
    function automatic logic [19:0] expv(logic [3:0] st, logic mr, logic rst);
        logic       ir, adr, np, rw, mw, br, op, mq, fs, ft;
        logic [1:0] sa, sb2, rs;
        {ir, adr, np, rw, mw, br, op, mq, fs, ft} = '0;
        sa = 2'b00; sb2 = 2'b00; rs = 2'b00;
        case (st)
            S_FETCH:  begin mq = 1; sa = 2'b01; sb2 = 2'b10; rs = 2'b10; np = mr; ir = mr; end
            S_DECODE: begin sa = 2'b01; sb2 = 2'b10; rs = 2'b10; end
            S_MEMADR: sb2 = 2'b01;
            S_MEMRD:  begin adr = 1; mq = 1; end
            S_MEMWB:  begin rw = 1; rs = 2'b01; end
            S_MEMWR:  begin adr = 1; mq = 1; mw = 1; end
            S_EXER:   op = 1;
            S_EXEI:   begin op = 1; sb2 = 2'b01; end
            S_ALUWB:  rw = 1;
            S_BRANCH: begin br = 1; rs = 2'b10; sb2 = 2'b01; end
            S_FAULT:  ft = 1;
            S_EXEF:   fs = 1;
            S_FWB:    begin rw = 1; rs = 2'b11; end
            default:  ;
        endcase
        if (!rst) {np, ir, rw, mw, br, mq, fs} = '0;
        return {ir, adr, sa, sb2, rs, np, rw, mw, br, op, mq, fs, ft, st};
    endfunction

    function automatic logic [19:0] obs(int u);
        case (u)
            UA:      return va;
            UT:      return vt;
            default: return vn;
        endcase
    endfunction

    function automatic logic mr_of(int u);
        case (u)
            UA:      return bus_a.MemReady;
            UT:      return bus_t.MemReady;
            default: return bus_n.MemReady;
        endcase
    endfunction

    task automatic set_in(int u, logic [1:0] op, logic [5:0] f, logic mr, logic fd);
        case (u)
            UA:      begin bus_a.Op = op; bus_a.Funct = f; bus_a.MemReady = mr; bus_a.FPUDone = fd; end
            UT:      begin bus_t.Op = op; bus_t.Funct = f; bus_t.MemReady = mr; bus_t.FPUDone = fd; end
            default: begin bus_n.Op = op; bus_n.Funct = f; bus_n.MemReady = mr; bus_n.FPUDone = fd; end
        endcase
    endtask

    task automatic chk();
        exp_t        e;
        logic [19:0] o;
        e = sb.pop_front();
        o = obs(e.unit);
        n_total++;
        assert (o === e.v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
        end
    endtask

    // Inputs are applied at the falling edge; the expectation is queued then checked 1 time unit later.
    task automatic cyc(string tag, int u, logic [3:0] st);
        exp_t e;
        e.tag  = tag;
        e.unit = u;
        e.v    = expv(st, mr_of(u), reset);
        sb.push_back(e);
        #1;
        chk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(UA, 2'b00, 6'h00, 1'b0, 1'b0);
        set_in(UT, 2'b00, 6'h00, 1'b0, 1'b0);
        set_in(UN, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(UA, 2'b00, 6'h00, 1'b1, 1'b0);
        set_in(UT, 2'b00, 6'h00, 1'b1, 1'b0);
        set_in(UN, 2'b00, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        cyc("rst_a", UA, S_FETCH);
        cyc("rst_t", UT, S_FETCH);
        cyc("rst_n", UN, S_FETCH);
        reset = 1'b1;

        // R-type ADD then ADDI, MemReady high throughout
        cyc("add_fetch", UA, S_FETCH);
        cyc("add_decode", UA, S_DECODE);
        cyc("add_exec", UA, S_EXER);
        cyc("add_wb", UA, S_ALUWB);
        set_in(UA, 2'b00, 6'h20, 1'b1, 1'b0);
        cyc("addi_fetch", UA, S_FETCH);
        cyc("addi_decode", UA, S_DECODE);
        cyc("addi_exec", UA, S_EXEI);
        cyc("addi_wb", UA, S_ALUWB);

        // LDR with three memory wait cycles
        set_in(UA, 2'b01, 6'h01, 1'b1, 1'b0);
        cyc("ldr_fetch", UA, S_FETCH);
        cyc("ldr_decode", UA, S_DECODE);
        cyc("ldr_adr", UA, S_MEMADR);
        set_in(UA, 2'b01, 6'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc($sformatf("ldr_rd%0d", i), UA, S_MEMRD);
        set_in(UA, 2'b01, 6'h01, 1'b1, 1'b0);
        cyc("ldr_rd3", UA, S_MEMRD);
        cyc("ldr_wb", UA, S_MEMWB);

        // Fetch stall, then branch
        set_in(UA, 2'b10, 6'h00, 1'b0, 1'b0);
        cyc("br_stall0", UA, S_FETCH);
        cyc("br_stall1", UA, S_FETCH);
        set_in(UA, 2'b10, 6'h00, 1'b1, 1'b0);
        cyc("br_fetch", UA, S_FETCH);
        cyc("br_decode", UA, S_DECODE);
        cyc("br_branch", UA, S_BRANCH);

        // FPU op, FPUDone in the 5th FWAIT cycle; MemReady there is ignored
        set_in(UA, 2'b11, 6'h00, 1'b1, 1'b0);
        cyc("fpu_fetch", UA, S_FETCH);
        cyc("fpu_decode", UA, S_DECODE);
        cyc("fpu_start", UA, S_EXEF);
        for (int i = 0; i < 4; i++) cyc($sformatf("fpu_wait%0d", i), UA, S_FWAIT);
        set_in(UA, 2'b11, 6'h00, 1'b1, 1'b1);
        cyc("fpu_wait4", UA, S_FWAIT);
        set_in(UA, 2'b11, 6'h00, 1'b1, 1'b0);
        cyc("fpu_wb", UA, S_FWB);

        // STR with two wait cycles
        set_in(UA, 2'b01, 6'h00, 1'b1, 1'b0);
        cyc("str_fetch", UA, S_FETCH);
        cyc("str_decode", UA, S_DECODE);
        cyc("str_adr", UA, S_MEMADR);
        set_in(UA, 2'b01, 6'h00, 1'b0, 1'b0);
        cyc("str_wr0", UA, S_MEMWR);
        cyc("str_wr1", UA, S_MEMWR);
        set_in(UA, 2'b01, 6'h00, 1'b1, 1'b0);
        cyc("str_wr2", UA, S_MEMWR);

        // MemReady arrives in the very cycle the watchdog expires: normal transition wins
        set_in(UA, 2'b01, 6'h01, 1'b1, 1'b0);
        cyc("wd_fetch", UA, S_FETCH);
        cyc("wd_decode", UA, S_DECODE);
        cyc("wd_adr", UA, S_MEMADR);
        set_in(UA, 2'b01, 6'h01, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc($sformatf("wd_rd%0d", i), UA, S_MEMRD);
        set_in(UA, 2'b01, 6'h01, 1'b1, 1'b0);
        cyc("wd_rd16", UA, S_MEMRD);
        cyc("wd_wb", UA, S_MEMWB);
        cyc("wd_refetch", UA, S_FETCH);

        // TIMEOUT=4: FETCH stuck, FAULT on the 5th edge, sticky, cleared by reset
        do_reset();
        for (int i = 0; i < 5; i++) cyc($sformatf("to_fetch%0d", i), UT, S_FETCH);
        set_in(UT, 2'b00, 6'h00, 1'b1, 1'b1);
        cyc("to_fault0", UT, S_FAULT);
        cyc("to_fault1", UT, S_FAULT);
        reset = 1'b0;
        cyc("to_reset", UT, S_FETCH);
        reset = 1'b1;

        // TIMEOUT=4: FPUDone stuck in FWAIT
        set_in(UT, 2'b11, 6'h00, 1'b1, 1'b0);
        cyc("tf_fetch", UT, S_FETCH);
        cyc("tf_decode", UT, S_DECODE);
        cyc("tf_start", UT, S_EXEF);
        set_in(UT, 2'b11, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc($sformatf("tf_wait%0d", i), UT, S_FWAIT);
        cyc("tf_fault", UT, S_FAULT);

        // Reset in the middle of a MEMWR wait
        do_reset();
        set_in(UT, 2'b01, 6'h00, 1'b1, 1'b0);
        cyc("rw_fetch", UT, S_FETCH);
        cyc("rw_decode", UT, S_DECODE);
        cyc("rw_adr", UT, S_MEMADR);
        set_in(UT, 2'b01, 6'h00, 1'b0, 1'b0);
        cyc("rw_wr0", UT, S_MEMWR);
        cyc("rw_wr1", UT, S_MEMWR);
        reset = 1'b0;
        cyc("rw_reset", UT, S_FETCH);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc($sformatf("rw_fetch%0d", i), UT, S_FETCH);
        cyc("rw_fault", UT, S_FAULT);

        // FPU_EN=0: Op=11 faults straight from DECODE
        do_reset();
        set_in(UN, 2'b11, 6'h00, 1'b1, 1'b0);
        cyc("nf_fetch", UN, S_FETCH);
        cyc("nf_decode", UN, S_DECODE);
        cyc("nf_fault0", UN, S_FAULT);
        cyc("nf_fault1", UN, S_FAULT);

        n_total++;
        assert (sb.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
